// File: rtl/swap_request_ctrl_pkg.sv
// Shared definitions for the swap request controller: FSM encoding and the
// default completion timeout.
package swap_request_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 8;

endpackage

// File: rtl/swap_request_ctrl_req_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse on
// each synchronized rising edge.
module req_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    // s1/s2 resolve metastability; s3 is the previous s2 for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/swap_request_ctrl.sv
// Command stage for the 3-register rotate/swap FSM: one w start pulse per
// request edge, with request queuing, completion counting and error flags.
module swap_request_ctrl
    import swap_request_ctrl_pkg::*;
#(
    parameter int PEND_W  = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              done,
    output logic              w,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  swaps,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic              req_edge;
    logic              issue;
    logic              swap_done;
    logic              timeout_hit;
    logic [WAIT_W-1:0] wait_cnt;

    req_sync_edge u_req_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (req),
        .rise     (req_edge)
    );

    // Handshake with the swap FSM: w is a one-cycle start strobe raised only in
    // ISSUE; done is a one-cycle completion strobe honoured only in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        swap_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (pending != '0) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (done) begin
                    swap_done = 1'b1;
                    state_nxt = GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign issue = (state == ISSUE);
    assign w     = issue;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    // A new request arriving in the same cycle as an issue nets out, so the
    // queue never overflows in that case even when it is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            swaps       <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (req_edge && !issue) begin
                if (pending == PEND_MAX) overflow <= 1'b1;
                else                     pending  <= pending + 1'b1;
            end else if (issue && !req_edge) begin
                pending <= pending - 1'b1;
            end
            if (swap_done)   swaps       <= swaps + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

endmodule
